// File: rtl/mure_pkg.sv
// Shared types and opcode match constants for the MURE micro-op packer.
// Instruction-class decoding and block/queue entries are defined here once.
package mure_pkg;

    localparam int NRET        = 2;
    localparam int INST_LEN    = 32;
    localparam int IRETIRE_LEN = 3;

    typedef enum logic [2:0] {
        ITYPE_STD  = 3'd0,
        ITYPE_EXC  = 3'd1,
        ITYPE_INT  = 3'd2,
        ITYPE_ERET = 3'd3,
        ITYPE_NTB  = 3'd4,
        ITYPE_TB   = 3'd5,
        ITYPE_UIJ  = 3'd6
    } itype_e;

    typedef struct packed {
        itype_e                 itype;
        logic [INST_LEN-1:0]    iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
    } uop_entry_s;

    typedef struct packed {
        logic [INST_LEN-1:0]    iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic                   empty;
    } block_s;

    localparam block_s EMPTY_BLOCK = '{iaddr: '0, iretire: '0, ilastsize: 1'b0, empty: 1'b1};

    localparam logic [INST_LEN-1:0] MASK_BEQ      = 32'h0000707f, MATCH_BEQ      = 32'h00000063;
    localparam logic [INST_LEN-1:0] MASK_BNE      = 32'h0000707f, MATCH_BNE      = 32'h00001063;
    localparam logic [INST_LEN-1:0] MASK_BLT      = 32'h0000707f, MATCH_BLT      = 32'h00004063;
    localparam logic [INST_LEN-1:0] MASK_BGE      = 32'h0000707f, MATCH_BGE      = 32'h00005063;
    localparam logic [INST_LEN-1:0] MASK_BLTU     = 32'h0000707f, MATCH_BLTU     = 32'h00006063;
    localparam logic [INST_LEN-1:0] MASK_BGEU     = 32'h0000707f, MATCH_BGEU     = 32'h00007063;
    localparam logic [INST_LEN-1:0] MASK_P_BEQIMM = 32'h0000707f, MATCH_P_BEQIMM = 32'h00002063;
    localparam logic [INST_LEN-1:0] MASK_P_BNEIMM = 32'h0000707f, MATCH_P_BNEIMM = 32'h00003063;
    localparam logic [INST_LEN-1:0] MASK_C_BEQZ   = 32'h0000e003, MATCH_C_BEQZ   = 32'h0000c001;
    localparam logic [INST_LEN-1:0] MASK_C_BNEZ   = 32'h0000e003, MATCH_C_BNEZ   = 32'h0000e001;
    localparam logic [INST_LEN-1:0] MASK_JALR     = 32'h0000707f, MATCH_JALR     = 32'h00000067;
    localparam logic [INST_LEN-1:0] MASK_C_JR     = 32'h0000f07f, MATCH_C_JR     = 32'h00008002;
    localparam logic [INST_LEN-1:0] MASK_C_JALR   = 32'h0000f07f, MATCH_C_JALR   = 32'h00009002;
    localparam logic [INST_LEN-1:0] MASK_MRET     = 32'hffffffff, MATCH_MRET     = 32'h30200073;
    localparam logic [INST_LEN-1:0] MASK_SRET     = 32'hffffffff, MATCH_SRET     = 32'h10200073;
    localparam logic [INST_LEN-1:0] MASK_URET     = 32'hffffffff, MATCH_URET     = 32'h00200073;

    function automatic logic op_hit(input logic [INST_LEN-1:0] word,
                                    input logic [INST_LEN-1:0] mask,
                                    input logic [INST_LEN-1:0] match);
        return (word & mask) == match;
    endfunction

    function automatic uop_entry_s block_entry(input itype_e itype, input block_s blk);
        return '{itype: itype, iaddr: blk.iaddr, iretire: blk.iretire, ilastsize: blk.ilastsize};
    endfunction

endpackage

// File: rtl/mure_itype_detect.sv
// Combinational classifier for one retire slot (EXC > INT > ERET > branch > UIJ > STD).
// Define MURE_PULP_BRANCH_EN to treat P.BEQIMM / P.BNEIMM as conditional branches.
module mure_itype_detect
    import mure_pkg::*;
(
    input  logic [INST_LEN-1:0] inst,
    input  logic                compressed,
    input  logic                taken,
    input  logic                exception,
    input  logic                interrupt,
    output itype_e              itype
);

    logic [INST_LEN-1:0] inst16;
    logic                is_eret;
    logic                is_branch;
    logic                is_uij;

    // 32-bit patterns only apply to full-width words; compressed words only see their low half.
    // NOTE: every output of this block is assigned on all paths, so no latch can be inferred.
    always_comb begin
        inst16    = {{(INST_LEN-16){1'b0}}, inst[15:0]};
        is_eret   = !compressed && (op_hit(inst, MASK_MRET, MATCH_MRET) ||
                                    op_hit(inst, MASK_SRET, MATCH_SRET) ||
                                    op_hit(inst, MASK_URET, MATCH_URET));
        is_branch = (!compressed && (op_hit(inst, MASK_BEQ,  MATCH_BEQ)  ||
                                     op_hit(inst, MASK_BNE,  MATCH_BNE)  ||
                                     op_hit(inst, MASK_BLT,  MATCH_BLT)  ||
                                     op_hit(inst, MASK_BGE,  MATCH_BGE)  ||
                                     op_hit(inst, MASK_BLTU, MATCH_BLTU) ||
                                     op_hit(inst, MASK_BGEU, MATCH_BGEU))) ||
                    (compressed && (op_hit(inst16, MASK_C_BEQZ, MATCH_C_BEQZ) ||
                                    op_hit(inst16, MASK_C_BNEZ, MATCH_C_BNEZ)));
`ifdef MURE_PULP_BRANCH_EN
        if (!compressed && (op_hit(inst, MASK_P_BEQIMM, MATCH_P_BEQIMM) ||
                            op_hit(inst, MASK_P_BNEIMM, MATCH_P_BNEIMM))) begin
            is_branch = 1'b1;
        end
`endif
        is_uij    = (!compressed && op_hit(inst, MASK_JALR, MATCH_JALR)) ||
                    (compressed && (op_hit(inst16, MASK_C_JR,   MATCH_C_JR) ||
                                    op_hit(inst16, MASK_C_JALR, MATCH_C_JALR)));

        if (exception)      itype = ITYPE_EXC;
        else if (interrupt) itype = ITYPE_INT;
        else if (is_eret)   itype = ITYPE_ERET;
        else if (is_branch) itype = taken ? ITYPE_TB : ITYPE_NTB;
        else if (is_uij)    itype = ITYPE_UIJ;
        else                itype = ITYPE_STD;
    end

endmodule

// File: rtl/mure_uop_packer.sv
// Packs retired instructions into trace blocks and queues them as micro-op entries.
// Slots are folded in program order each cycle; finished blocks enter a QDEPTH-entry FIFO.
module mure_uop_packer
    import mure_pkg::*;
#(
    parameter int NRET   = mure_pkg::NRET,
    parameter int QDEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NRET-1:0]                valid_i,
    input  logic [NRET-1:0][INST_LEN-1:0]  iaddr_i,
    input  logic [NRET-1:0][INST_LEN-1:0]  inst_i,
    input  logic [NRET-1:0]                compressed_i,
    input  logic [NRET-1:0]                taken_i,
    input  logic [NRET-1:0]                exception_i,
    input  logic [NRET-1:0]                interrupt_i,
    input  logic                           flush_i,
    output logic                           ready_o,
    output logic                           uop_valid_o,
    output uop_entry_s                     uop_o,
    input  logic                           uop_ready_i
);

    localparam int MAXP = 2*NRET + 1;
    localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW   = $clog2(QDEPTH + 1);
    localparam int PCW  = $clog2(MAXP + 1);
    localparam int IW   = IRETIRE_LEN + 1;
    localparam logic [IW-1:0] IRETIRE_MAX = {1'b0, {IRETIRE_LEN{1'b1}}};

    itype_e          slot_type [NRET];
    block_s          blk_q, blk_n;
    uop_entry_s      mem [QDEPTH];
    uop_entry_s      push_q [MAXP];
    logic [PCW-1:0]  push_cnt;
    logic [PW-1:0]   wptr_q, rptr_q, wptr_n, rptr_n;
    logic [PW-1:0]   wr_idx [MAXP];
    logic [MAXP-1:0] wr_en;
    logic [CW-1:0]   count_q, count_n;
    logic            trapped;
    logic            pop;
    logic [IW-1:0]   inc, sum;
    int              free, n_acc;

    for (genvar g = 0; g < NRET; g++) begin : g_detect
        mure_itype_detect u_detect (
            .inst       (inst_i[g]),
            .compressed (compressed_i[g]),
            .taken      (taken_i[g]),
            .exception  (exception_i[g]),
            .interrupt  (interrupt_i[g]),
            .itype      (slot_type[g])
        );
    end

    assign uop_valid_o = (count_q != '0);
    assign uop_o       = uop_valid_o ? mem[rptr_q] : '0;
    assign ready_o     = (QDEPTH - int'(count_q)) >= 2*NRET;
    assign pop         = uop_valid_o && uop_ready_i;

    // NOTE: blocking assignments here are deliberate: each slot must see the block
    // as already updated by the earlier slots of the same cycle.
    always_comb begin
        blk_n    = blk_q;
        push_cnt = '0;
        trapped  = 1'b0;
        inc      = '0;
        sum      = '0;
        for (int k = 0; k < MAXP; k++) push_q[k] = '0;

        for (int s = 0; s < NRET; s++) begin
            if (valid_i[s] && !trapped) begin
                if (slot_type[s] == ITYPE_EXC || slot_type[s] == ITYPE_INT) begin
                    if (blk_n.empty) begin
                        push_q[push_cnt] = '{itype: slot_type[s], iaddr: iaddr_i[s],
                                             iretire: '0, ilastsize: 1'b0};
                    end else begin
                        push_q[push_cnt] = block_entry(slot_type[s], blk_n);
                    end
                    push_cnt = push_cnt + PCW'(1);
                    blk_n    = EMPTY_BLOCK;
                    trapped  = 1'b1;
                end else begin
                    inc = compressed_i[s] ? IW'(1) : IW'(2);
                    sum = {1'b0, blk_n.iretire} + inc;
                    // A block never holds more than IRETIRE_MAX halfwords; close it first.
                    if (!blk_n.empty && sum > IRETIRE_MAX) begin
                        push_q[push_cnt] = block_entry(ITYPE_STD, blk_n);
                        push_cnt         = push_cnt + PCW'(1);
                        blk_n            = EMPTY_BLOCK;
                    end
                    if (blk_n.empty) begin
                        blk_n.iaddr = iaddr_i[s];
                        sum         = inc;
                    end
                    blk_n.iretire   = sum[IRETIRE_LEN-1:0];
                    blk_n.ilastsize = !compressed_i[s];
                    blk_n.empty     = 1'b0;
                    if (slot_type[s] != ITYPE_STD) begin
                        push_q[push_cnt] = block_entry(slot_type[s], blk_n);
                        push_cnt         = push_cnt + PCW'(1);
                        blk_n            = EMPTY_BLOCK;
                    end
                end
            end
        end

        if (flush_i && !blk_n.empty) begin
            push_q[push_cnt] = block_entry(ITYPE_STD, blk_n);
            push_cnt         = push_cnt + PCW'(1);
            blk_n            = EMPTY_BLOCK;
        end
    end

    // Entries beyond the free space are dropped rather than overwriting queued ones.
    always_comb begin
        free    = QDEPTH - int'(count_q) + (pop ? 1 : 0);
        n_acc   = (int'(push_cnt) < free) ? int'(push_cnt) : free;
        for (int k = 0; k < MAXP; k++) begin
            wr_idx[k] = PW'((int'(wptr_q) + k) % QDEPTH);
            wr_en[k]  = (k < n_acc);
        end
        wptr_n  = PW'((int'(wptr_q) + n_acc) % QDEPTH);
        rptr_n  = pop ? PW'((int'(rptr_q) + 1) % QDEPTH) : rptr_q;
        count_n = CW'(int'(count_q) + n_acc - (pop ? 1 : 0));
    end

    // NOTE: queue storage is not reset; count_q alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int k = 0; k < MAXP; k++) begin
                if (wr_en[k]) mem[wr_idx[k]] <= push_q[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            blk_q   <= EMPTY_BLOCK;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            blk_q   <= blk_n;
            wptr_q  <= wptr_n;
            rptr_q  <= rptr_n;
            count_q <= count_n;
        end
    end

endmodule

// File: tb/tb_mure_uop_packer.sv
// Self-checking bench for mure_uop_packer: directed scenarios then randomized traffic
// compared against a queue-based reference model of the block-packing rules.
module tb_mure_uop_packer;
    import mure_pkg::*;

    localparam int QDEPTH = 4;
`ifdef MURE_PULP_BRANCH_EN
    localparam bit PULP_BR = 1'b1;
`else
    localparam bit PULP_BR = 1'b0;
`endif

    localparam logic [31:0] I_ADDI  = 32'h00108093;
    localparam logic [31:0] I_BEQ   = 32'h00000063;
    localparam logic [31:0] I_JALR  = 32'h000080e7;
    localparam logic [31:0] I_MRET  = 32'h30200073;
    localparam logic [31:0] I_CADDI = 32'h00000085;

    logic                          clk = 1'b0;
    logic                          rst_ni;
    logic [NRET-1:0]               valid_i, compressed_i, taken_i, exception_i, interrupt_i;
    logic [NRET-1:0][INST_LEN-1:0] iaddr_i, inst_i;
    logic                          flush_i, ready_o, uop_valid_o, uop_ready_i;
    uop_entry_s                    uop_o;

    int checks = 0;
    int errors = 0;

    uop_entry_s  mq [$];
    bit          m_empty;
    logic [31:0] m_addr;
    int          m_iret;
    bit          m_last;

    always #5 clk = ~clk;

    mure_uop_packer #(.NRET(NRET), .QDEPTH(QDEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .iaddr_i      (iaddr_i),
        .inst_i       (inst_i),
        .compressed_i (compressed_i),
        .taken_i      (taken_i),
        .exception_i  (exception_i),
        .interrupt_i  (interrupt_i),
        .flush_i      (flush_i),
        .ready_o      (ready_o),
        .uop_valid_o  (uop_valid_o),
        .uop_o        (uop_o),
        .uop_ready_i  (uop_ready_i)
    );

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish in time");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic uop_entry_s mk(input itype_e t, input logic [31:0] a, input int n, input bit l);
        return '{itype: t, iaddr: a, iretire: IRETIRE_LEN'(n), ilastsize: l};
    endfunction

    function automatic uop_entry_s m_block(input itype_e t);
        return mk(t, m_addr, m_iret, m_last);
    endfunction

    // Field-level decode of the instruction classes, independent of mask tables.
    function automatic itype_e classify(input logic [31:0] w, input bit c, input bit t,
                                        input bit e, input bit i);
        logic [2:0] f3;
        f3 = w[14:12];
        if (e) return ITYPE_EXC;
        if (i) return ITYPE_INT;
        if (!c && (w == 32'h30200073 || w == 32'h10200073 || w == 32'h00200073)) return ITYPE_ERET;
        if (!c && w[6:0] == 7'h63 && ((f3 != 3'd2 && f3 != 3'd3) || PULP_BR))
            return t ? ITYPE_TB : ITYPE_NTB;
        if (c && w[1:0] == 2'b01 && w[15:14] == 2'b11) return t ? ITYPE_TB : ITYPE_NTB;
        if (!c && w[6:0] == 7'h67 && f3 == 3'd0) return ITYPE_UIJ;
        if (c && w[1:0] == 2'b10 && w[15:13] == 3'b100 && w[6:2] == 5'd0) return ITYPE_UIJ;
        return ITYPE_STD;
    endfunction

    task automatic model_cycle();
        uop_entry_s pq [$];
        bit         trapped = 0;
        itype_e     t;
        int         inc;
        if (mq.size() > 0 && uop_ready_i) void'(mq.pop_front());
        for (int s = 0; s < NRET; s++) begin
            if (valid_i[s] && !trapped) begin
                t = classify(inst_i[s], compressed_i[s], taken_i[s], exception_i[s], interrupt_i[s]);
                if (t == ITYPE_EXC || t == ITYPE_INT) begin
                    pq.push_back(m_empty ? mk(t, iaddr_i[s], 0, 0) : m_block(t));
                    m_empty = 1;
                    trapped = 1;
                end else begin
                    inc = compressed_i[s] ? 1 : 2;
                    if (!m_empty && m_iret + inc > 7) begin
                        pq.push_back(m_block(ITYPE_STD));
                        m_empty = 1;
                    end
                    if (m_empty) begin
                        m_addr  = iaddr_i[s];
                        m_iret  = 0;
                        m_empty = 0;
                    end
                    m_iret += inc;
                    m_last  = !compressed_i[s];
                    if (t != ITYPE_STD) begin
                        pq.push_back(m_block(t));
                        m_empty = 1;
                    end
                end
            end
        end
        if (flush_i && !m_empty) begin
            pq.push_back(m_block(ITYPE_STD));
            m_empty = 1;
        end
        foreach (pq[k]) if (mq.size() < QDEPTH) mq.push_back(pq[k]);
    endtask

    task automatic clear_inputs();
        valid_i = '0; compressed_i = '0; taken_i = '0; exception_i = '0; interrupt_i = '0;
        iaddr_i = '0; inst_i = '0; flush_i = 1'b0;
    endtask

    task automatic step();
        check("uop_valid", 64'(uop_valid_o), 64'(mq.size() > 0));
        if (mq.size() > 0) check("uop", 64'(uop_o), 64'(mq[0]));
        check("ready", 64'(ready_o), 64'((QDEPTH - mq.size()) >= 2*NRET));
        model_cycle();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        uop_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        mq.delete();
        m_empty = 1;
        m_iret  = 0;
        check("rst_valid", 64'(uop_valid_o), 64'(0));
        check("rst_uop",   64'(uop_o),       64'(0));
        check("rst_ready", 64'(ready_o),     64'(1));
    endtask

    task automatic slot(input int s, input logic [31:0] a, input logic [31:0] w,
                        input bit c, input bit t = 1'b0);
        valid_i[s]      = 1'b1;
        iaddr_i[s]      = a;
        inst_i[s]       = w;
        compressed_i[s] = c;
        taken_i[s]      = t;
    endtask

    task automatic expect_head(input string tag, input uop_entry_s exp);
        check({tag, "_valid"}, 64'(uop_valid_o), 64'(1));
        check(tag, 64'(uop_o), 64'(exp));
        uop_ready_i = 1'b1;
        step();
        uop_ready_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst(input int kind, output bit c);
        logic [2:0] f3;
        logic [3:0] sel;
        c = 0;
        case (kind)
            4: begin c = 1; return {16'($urandom), 3'b000, 1'($urandom), 5'd1, 5'($urandom), 2'b01}; end
            5: begin
                sel = 4'($urandom_range(0, 5));
                f3  = (sel < 2) ? 3'(sel) : 3'(sel + 2);
                return {7'($urandom), 10'($urandom), f3, 5'($urandom), 7'h63};
            end
            6: return {7'($urandom), 10'($urandom), 2'b01, 1'($urandom), 5'($urandom), 7'h63};
            7: begin c = 1; return {16'($urandom), 2'b11, 1'($urandom), 11'($urandom), 2'b01}; end
            8: begin
                if ($urandom_range(0, 1) == 1) return {17'($urandom), 3'b000, 5'($urandom), 7'h67};
                c = 1;
                return {16'($urandom), 3'b100, 1'($urandom), 5'($urandom_range(1, 31)), 5'd0, 2'b10};
            end
            9: begin
                sel = 4'($urandom_range(0, 2));
                return (sel == 0) ? 32'h30200073 : (sel == 1) ? 32'h10200073 : 32'h00200073;
            end
            default: return {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h13};
        endcase
    endfunction

    initial begin
        logic [31:0] pc;
        logic [31:0] w;
        bit          c;

        do_reset();

        // Three 32-bit STD then taken BEQ: overflow splits the block.
        slot(0, 32'h100, I_ADDI, 0); slot(1, 32'h104, I_ADDI, 0); step();
        slot(0, 32'h108, I_ADDI, 0); slot(1, 32'h10C, I_BEQ, 0, 1); step();
        expect_head("ovf_std", mk(ITYPE_STD, 32'h100, 6, 1));
        expect_head("ovf_tb",  mk(ITYPE_TB,  32'h10C, 2, 1));

        // Seven compressed STD then flush: block of exactly 7 halfwords.
        for (int i = 0; i < 4; i++) begin
            slot(0, 32'h200 + 32'(4*i), I_CADDI, 1);
            if (i < 3) slot(1, 32'h202 + 32'(4*i), I_CADDI, 1);
            step();
        end
        flush_i = 1'b1; step();
        expect_head("flush7", mk(ITYPE_STD, 32'h200, 7, 0));

        // JALR and MRET in one cycle.
        slot(0, 32'h300, I_JALR, 0); slot(1, 32'h304, I_MRET, 0); step();
        expect_head("uij",  mk(ITYPE_UIJ,  32'h300, 2, 1));
        expect_head("eret", mk(ITYPE_ERET, 32'h304, 2, 1));

        // Exception on slot0 with empty block; slot1 ignored.
        slot(0, 32'h400, I_ADDI, 0); exception_i[0] = 1'b1; slot(1, 32'h404, I_ADDI, 0); step();
        expect_head("exc", mk(ITYPE_EXC, 32'h400, 0, 0));
        check("exc_only_one", 64'(uop_valid_o), 64'(0));
        flush_i = 1'b1; step();
        check("exc_slot1_dropped", 64'(uop_valid_o), 64'(0));

        // Back-pressure: fill the queue, then drop excess, then drain in order.
        slot(0, 32'h500, I_JALR, 0); slot(1, 32'h504, I_JALR, 0); step();
        check("bp_ready_low", 64'(ready_o), 64'(0));
        slot(0, 32'h508, I_JALR, 0); slot(1, 32'h50C, I_JALR, 0); step();
        slot(0, 32'h510, I_JALR, 0); slot(1, 32'h514, I_JALR, 0); step();
        expect_head("bp0", mk(ITYPE_UIJ, 32'h500, 2, 1));
        expect_head("bp1", mk(ITYPE_UIJ, 32'h504, 2, 1));
        expect_head("bp2", mk(ITYPE_UIJ, 32'h508, 2, 1));
        expect_head("bp3", mk(ITYPE_UIJ, 32'h50C, 2, 1));
        check("bp_empty", 64'(uop_valid_o), 64'(0));
        check("bp_ready_back", 64'(ready_o), 64'(1));

        // Reset with two queued entries and a pending block.
        slot(0, 32'h600, I_JALR, 0); slot(1, 32'h604, I_JALR, 0); step();
        slot(0, 32'h608, I_ADDI, 0); step();
        do_reset();
        slot(0, 32'h700, I_ADDI, 0); flush_i = 1'b1; step();
        expect_head("post_rst", mk(ITYPE_STD, 32'h700, 2, 1));

        // Randomized traffic against the reference model.
        pc = 32'h1000;
        repeat (1500) begin
            uop_ready_i = ($urandom_range(0, 9) < 6);
            if ((QDEPTH - mq.size()) >= 2*NRET) begin
                for (int s = 0; s < NRET; s++) begin
                    if ($urandom_range(0, 9) < 7) begin
                        w = rand_inst($urandom_range(0, 9), c);
                        slot(s, pc, w, c, 1'($urandom_range(0, 1)));
                        exception_i[s] = ($urandom_range(0, 24) == 0);
                        interrupt_i[s] = ($urandom_range(0, 24) == 0);
                        pc = pc + (c ? 32'd2 : 32'd4);
                    end
                end
                flush_i = ($urandom_range(0, 9) == 0);
            end
            step();
        end

        uop_ready_i = 1'b1;
        flush_i = 1'b1;
        step();
        for (int n = 0; n < 20 && mq.size() > 0; n++) step();
        check("drain_empty", 64'(uop_valid_o), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mure_uop_packer.md
MURE_UOP_PACKER -- requirements
Module: mure_uop_packer

Interface
REQ-001 SHALL have parameter NRET, default mure_pkg::NRET (2); retire slots per cycle, program order slot 0 first.
REQ-002 SHALL have parameter QDEPTH, default 4; output queue entries, minimum 2*NRET.
REQ-003 SHALL have port clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port valid_i  in  NRET  slot carries a retired instruction, or a trapping one.
REQ-006 SHALL have port iaddr_i  in  NRET x INST_LEN  instruction address per slot.
REQ-007 SHALL have port inst_i  in  NRET x INST_LEN  instruction word; compressed instructions sit in the low 16 bits.
REQ-008 SHALL have port compressed_i  in  NRET  16-bit instruction.
REQ-009 SHALL have port taken_i  in  NRET  branch in the slot was taken.
REQ-010 SHALL have ports exception_i and interrupt_i  in  NRET  slot traps and does not retire.
REQ-011 SHALL have port flush_i  in  1  force out the pending block.
REQ-012 SHALL have port ready_o  out  1  high when the queue has at least 2*NRET free entries.
REQ-013 SHALL have ports uop_valid_o  out  1, uop_o  out  uop_entry_s, and uop_ready_i  in  1; queue head handshake.

Function
REQ-014 SHALL classify each slot by priority:
- EXC if exception_i; INT if interrupt_i.
- ERET on an MRET, SRET or URET match.
- Branch on a BEQ, BNE, BLT, BGE, BLTU, BGEU, C.BEQZ or C.BNEZ match: TB if taken_i, else NTB.
- UIJ on a JALR, C.JR or C.JALR match.
- STD otherwise.
REQ-015 SHALL keep a pending block holding start iaddr, iretire (halfwords, IRETIRE_LEN bits), ilastsize and an empty flag.
REQ-016 SHALL handle a retiring STD slot as follows: if the block is empty, start iaddr = slot iaddr; add 1 to iretire for a compressed instruction, else 2; set ilastsize = !compressed.
REQ-017 SHALL, before adding an instruction that would push iretire above 7, push the block as itype STD and start a new one with that instruction.
REQ-018 SHALL, for a retiring non-STD slot (ERET/NTB/TB/UIJ), add it to the block, push the block with that itype, and leave the block empty.
REQ-019 SHALL, for an EXC/INT slot, push the block with itype EXC/INT without adding the slot; if the block is empty, push iaddr = slot iaddr, iretire = 0, ilastsize = 0. Slots after a trapping slot in the same cycle SHALL be ignored.
REQ-020 SHALL process slots sequentially within one cycle, with invalid slots skipped; each slot can push up to 2 entries.
REQ-021 SHALL, on flush_i, push a non-empty pending block as STD after that cycle's slots are processed; an empty block SHALL push nothing.
REQ-022 SHALL make a pushed entry visible on uop_valid_o the cycle after the push (1-cycle latency); order SHALL be FIFO.
REQ-023 SHALL allow pop and push in the same cycle; pop on uop_valid_o && uop_ready_i.
REQ-024 SHALL treat valid_i while ready_o is low as an upstream protocol violation; the queue SHALL never overwrite, and it SHALL drop the excess.
REQ-025 SHALL compute queue pointers modulo QDEPTH and keep a separate count of 0..QDEPTH.

Reset
REQ-026 SHALL, while rst_ni is low at a clock edge, set: queue empty, uop_valid_o=0, uop_o=0, pending block empty, iretire=0, ready_o=1 in the following cycle.
REQ-027 SHALL discard any pending block and queued entries on reset mid-operation, without output.

Configuration
REQ-028 SHALL, with MURE_PULP_BRANCH_EN defined, classify P.BEQIMM and P.BNEIMM as branches (TB/NTB); without it, they SHALL be STD.

Structure
REQ-029 SHALL take itype_e, uop_entry_s, the MASK_/MATCH_ constants, INST_LEN, IRETIRE_LEN and NRET from mure_pkg, with no local duplicates.
REQ-030 SHALL implement per-slot classification in combinational sub-module mure_itype_detect, instantiated NRET times.

Verification
REQ-031 SHALL cover: 3 STD 32-bit instructions at 0x100/0x104/0x108, then a taken BEQ at 0x10C -> 1 uop {TB, 0x100, iretire=8?}. Overflow applies: expected {STD,0x100,6,1} then {TB,0x10C,2,1}.
REQ-032 SHALL cover: 7 compressed STD instructions from 0x200, then flush_i -> {STD,0x200,7,0}.
REQ-033 SHALL cover: slot0 JALR at 0x300 and slot1 MRET at 0x304 in the same cycle -> {UIJ,0x300,2,1}, then {ERET,0x304,2,1}.
REQ-034 SHALL cover: empty block, exception_i on slot0 at 0x400, with slot1 valid -> single {EXC,0x400,0,0}; slot1 ignored.
REQ-035 SHALL cover: uop_ready_i=0 for 4 entries -> ready_o falls when free < 4; after release, entries drain in order with no loss.
REQ-036 SHALL cover: rst_ni low while a block is pending and 2 entries are queued -> uop_valid_o=0 next cycle, and the next block starts fresh.
